vec_s8_pack_stream: RTL

VEC_S8_PACK_STREAM -- requirements
Module: vec_s8_pack_stream

---
 rtl/vec_s8_pack_stream.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/vec_s8_pack_stream.sv
// vec_s8_pack_stream
//   Ping-pong packer: int8 vectors (VLEN lanes) are written into one of two
//   banks of DEPTH vectors. A bank is sealed on in_last or when it fills.
//   The read side then raises out_req and latches a per-vector byte count on
//   req_ack. It streams each stored vector as OUT_BYTES-wide beats with a
//   per-byte mask, and releases the bank on the out_last handshake.
//
//   Ports
//     clk, rstn             clock, async active-low reset
//     in_valid/in_ready     input vector handshake; in_last ends a batch
//     in_vec_s8             VLEN signed bytes, lane k = in_vec_s8[k]
//     out_req/req_ack       read bank ready / host ack with valid_num
//     out_valid/out_ready   output beat handshake
//     out_data/out_mask     beat bytes (byte k = lane k of the beat), byte valid
//     out_last              final beat of the bank
//     bank_sealed           per-bank sealed flags
//
//   Build option: VEC_PACK_ZERO_FILL_EN forces masked-out bytes to 8'h00;
//   otherwise they carry raw stored bank contents.

module vec_s8_pack_lane #(
  parameter int VNW = 5,
  parameter int K   = 0
) (
  input  logic [7:0]     raw,
  input  logic [VNW-1:0] base,
  input  logic [VNW-1:0] cnt,
  output logic [7:0]     dat,
  output logic           msk
);
  assign msk = (base + VNW'(K)) < cnt;
`ifdef VEC_PACK_ZERO_FILL_EN
  assign dat = msk ? raw : 8'h00;
`else
  assign dat = raw;
`endif
endmodule

module vec_s8_pack_stream #(
  parameter int VLEN      = 16,
  parameter int OUT_BYTES = 4,
  parameter int DEPTH     = 8
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          in_last,
  input  logic signed [VLEN-1:0][7:0]   in_vec_s8,
  output logic                          out_req,
  input  logic                          req_ack,
  input  logic [$clog2(VLEN):0]         valid_num,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [8*OUT_BYTES-1:0]        out_data,
  output logic [OUT_BYTES-1:0]          out_mask,
  output logic                          out_last,
  output logic [1:0]                    bank_sealed
);
  localparam int VNW = $clog2(VLEN) + 1;
  localparam int NB  = VLEN / OUT_BYTES;
  localparam int BW  = (NB > 1) ? $clog2(NB) : 1;
  localparam int OBL = $clog2(OUT_BYTES);
  localparam int CW  = $clog2(DEPTH + 1);
  localparam int VW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_STREAM} state_e;

  state_e                     state_q, state_d;
  logic                       wsel_q, wsel_d, rsel_q, rsel_d;
  logic [1:0][CW-1:0]         cnt_q, cnt_d;
  logic [1:0]                 sealed_q, sealed_d;
  logic [BW-1:0]              b_q, b_d;
  logic [VW-1:0]              v_q, v_d;
  logic [VNW-1:0]             lat_q, lat_d;
  logic                       out_valid_q, out_valid_d;
  logic                       out_last_q, out_last_d;
  logic [OUT_BYTES-1:0][7:0]  out_data_q, out_data_d;
  logic [OUT_BYTES-1:0]       out_mask_q, out_mask_d;

  logic [VLEN-1:0][7:0]       mem_q [2][DEPTH];

  logic                       acc, ld, rel;
  logic [CW-1:0]              wcnt, rcnt;
  logic [BW-1:0]              lastb_q, lastb_d;
  logic [VLEN-1:0][7:0]       rd_row;
  logic [NB-1:0][OUT_BYTES-1:0][7:0] rd_beats;
  logic [VNW-1:0]             beat_base;
  logic [OUT_BYTES-1:0][7:0]  beat_data;
  logic [OUT_BYTES-1:0]       beat_mask;

  assign in_ready    = ~sealed_q[wsel_q];
  assign acc         = in_valid & in_ready;
  assign wcnt        = cnt_q[wsel_q];
  assign rcnt        = cnt_q[rsel_q];
  assign out_req     = (state_q == S_REQ);
  assign out_valid   = out_valid_q;
  assign out_last    = out_last_q;
  assign out_data    = out_data_q;
  assign out_mask    = out_mask_q;
  assign bank_sealed = sealed_q;

  // Index of the last beat holding any masked-in byte; later beats are skipped.
  assign lastb_q = BW'((lat_q - VNW'(1)) >> OBL);
  assign lastb_d = BW'((lat_d - VNW'(1)) >> OBL);

  // Read sequencing: decides the next beat indices and when to release.
  always_comb begin
    state_d = state_q;
    b_d     = b_q;
    v_d     = v_q;
    lat_d   = lat_q;
    ld      = 1'b0;
    rel     = 1'b0;
    case (state_q)
      S_IDLE: if (sealed_q[rsel_q]) state_d = S_REQ;
      S_REQ: if (req_ack) begin
        lat_d = (valid_num > VNW'(VLEN)) ? VNW'(VLEN) : valid_num;
        b_d   = '0;
        v_d   = '0;
        if (lat_d == '0) begin
          rel     = 1'b1;
          state_d = S_IDLE;
        end else begin
          ld      = 1'b1;
          state_d = S_STREAM;
        end
      end
      S_STREAM: if (out_valid_q && out_ready) begin
        if (out_last_q) begin
          rel     = 1'b1;
          state_d = S_IDLE;
        end else begin
          ld = 1'b1;
          if (b_q == lastb_q) begin
            b_d = '0;
            v_d = v_q + VW'(1);
          end else begin
            b_d = b_q + BW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Beat formation from the *next* indices so the output registers load the
  // upcoming beat on the same edge as the handshake.
  assign rd_row    = mem_q[rsel_q][v_d];
  assign rd_beats  = rd_row;
  assign beat_base = VNW'(b_d) << OBL;

  for (genvar k = 0; k < OUT_BYTES; k++) begin : g_lane
    vec_s8_pack_lane #(.VNW(VNW), .K(k)) u_lane (
      .raw  (rd_beats[b_d][k]),
      .base (beat_base),
      .cnt  (lat_d),
      .dat  (beat_data[k]),
      .msk  (beat_mask[k])
    );
  end

  // Bank bookkeeping and output registers. Seal (write bank) and release
  // (read bank) always touch different banks, so both apply in one cycle.
  always_comb begin
    wsel_d      = wsel_q;
    rsel_d      = rsel_q;
    cnt_d       = cnt_q;
    sealed_d    = sealed_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_data_d  = out_data_q;
    out_mask_d  = out_mask_q;
    if (acc) begin
      cnt_d[wsel_q] = wcnt + CW'(1);
      if (in_last || (wcnt == CW'(DEPTH - 1))) begin
        sealed_d[wsel_q] = 1'b1;
        wsel_d           = ~wsel_q;
      end
    end
    if (rel) begin
      sealed_d[rsel_q] = 1'b0;
      cnt_d[rsel_q]    = '0;
      rsel_d           = ~rsel_q;
      out_valid_d      = 1'b0;
      out_last_d       = 1'b0;
    end
    if (ld) begin
      out_valid_d = 1'b1;
      out_data_d  = beat_data;
      out_mask_d  = beat_mask;
      out_last_d  = (CW'(v_d) == rcnt - CW'(1)) && (b_d == lastb_d);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      wsel_q      <= 1'b0;
      rsel_q      <= 1'b0;
      cnt_q       <= '0;
      sealed_q    <= '0;
      b_q         <= '0;
      v_q         <= '0;
      lat_q       <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      out_mask_q  <= '0;
    end else begin
      state_q     <= state_d;
      wsel_q      <= wsel_d;
      rsel_q      <= rsel_d;
      cnt_q       <= cnt_d;
      sealed_q    <= sealed_d;
      b_q         <= b_d;
      v_q         <= v_d;
      lat_q       <= lat_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
      out_mask_q  <= out_mask_d;
    end
  end

  // Bank storage is not reset; a sealed/count clear discards its contents.
  always_ff @(posedge clk) begin
    if (acc) mem_q[wsel_q][wcnt[VW-1:0]] <= in_vec_s8;
  end

endmodule
